// File: rtl/acorn128_dec_stream.sv
// Bit-serial ACORN-128 decryption engine: ciphertext in, plaintext out, state advanced one step per bit.
// Define ACORN_DEC_PAD_EN to build the PAD_STEPS-step post-message padding; otherwise DONE follows the last bit.
module acorn128_dec_stream #(
    parameter int PAD_STEPS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         load_empty,
    input  logic [292:0] state_in,
    input  logic         c_valid,
    input  logic         c_bit,
    input  logic         c_last,
    output logic         c_ready,
    output logic         p_valid,
    output logic         p_bit,
    input  logic         p_ready,
    output logic         done,
    output logic [292:0] state_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    logic [1:0]   fsm;
    logic [292:0] s;
    logic [292:0] t;
    logic [292:0] s_next;
    logic         ks;
    logic         f;
    logic         ca;
    logic         cb;
    logic         m;
    logic         accept;

    always_comb begin
        // NOTE: t starts as a full copy of s, so every bit is assigned on every pass and no latch is inferred.
        t      = s;
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];
    end

    assign ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);

`ifdef ACORN_DEC_PAD_EN
    localparam logic [1:0] ST_PAD  = 2'd2;
    localparam logic [1:0] ST_TAIL = ST_PAD;
    localparam int         CNT_W   = $clog2(PAD_STEPS) + 1;

    logic [CNT_W-1:0] pad_cnt;
    logic             in_pad;
    logic             pad_last;

    assign in_pad   = (fsm == ST_PAD);
    assign pad_last = (pad_cnt == CNT_W'(PAD_STEPS - 1));
    // Padding injects a single 1 at k=0 and keeps ca on for the first 128 steps.
    assign ca = in_pad ? (32'(pad_cnt) < 32'd128) : 1'b1;
    assign m  = in_pad ? (pad_cnt == '0) : (c_bit ^ ks);

    // Counter runs only while padding and sits at zero otherwise, so each message starts at k=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pad_cnt <= '0;
        else if (in_pad)
            pad_cnt <= pad_cnt + 1'b1;
        else
            pad_cnt <= '0;
    end
`else
    localparam logic [1:0] ST_TAIL = ST_DONE;

    // PAD_STEPS has no effect when padding is left to an external block.
    logic unused_pad_steps;
    assign unused_pad_steps = (PAD_STEPS > 0);

    assign ca = 1'b1;
    assign m  = c_bit ^ ks;
`endif

    assign cb     = 1'b0;
    assign f      = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
    assign s_next = {f ^ m, t[292:1]};

    // At most one plaintext bit is ever pending.
    assign c_ready   = (fsm == ST_RUN) & (~p_valid | p_ready);
    assign accept    = c_valid & c_ready;
    assign done      = (fsm == ST_DONE);
    assign state_out = s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
            fsm     <= ST_IDLE;
            s       <= '0;
            p_valid <= 1'b0;
            p_bit   <= 1'b0;
        end else begin
            if (p_ready)
                p_valid <= 1'b0;
            case (fsm)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        s   <= state_in;
                        fsm <= load_empty ? ST_TAIL : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        s       <= s_next;
                        p_bit   <= m;
                        p_valid <= 1'b1;
                        if (c_last)
                            fsm <= ST_TAIL;
                    end
                end
`ifdef ACORN_DEC_PAD_EN
                ST_PAD: begin
                    s <= s_next;
                    if (pad_last)
                        fsm <= ST_DONE;
                end
`endif
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acorn128_dec_stream.sv
// Self-checking bench for acorn128_dec_stream: fixed vectors, encrypt-model round trips, backpressure, reset.
module tb_acorn128_dec_stream;

    localparam int PAD_STEPS = 256;
`ifdef ACORN_DEC_PAD_EN
    localparam int PAD_LEN = PAD_STEPS;
`else
    localparam int PAD_LEN = 0;
`endif

    logic         clk;
    logic         rst;
    logic         load;
    logic         load_empty;
    logic [292:0] state_in;
    logic         c_valid;
    logic         c_bit;
    logic         c_last;
    logic         c_ready;
    logic         p_valid;
    logic         p_bit;
    logic         p_ready;
    logic         done;
    logic [292:0] state_out;

    acorn128_dec_stream #(.PAD_STEPS(PAD_STEPS)) dut (
        .clk(clk), .rst(rst), .load(load), .load_empty(load_empty), .state_in(state_in),
        .c_valid(c_valid), .c_bit(c_bit), .c_last(c_last), .c_ready(c_ready),
        .p_valid(p_valid), .p_bit(p_bit), .p_ready(p_ready), .done(done), .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_s(input string name, input logic [292:0] act, input logic [292:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: the cipher step written directly from the tap/keystream/feedback equations.
    function automatic logic tap(input logic [292:0] s, input int i);
        case (i)
            289: return s[289] ^ s[235] ^ s[230];
            230: return s[230] ^ s[196] ^ s[193];
            193: return s[193] ^ s[160] ^ s[154];
            154: return s[154] ^ s[111] ^ s[107];
            107: return s[107] ^ s[66]  ^ s[61];
            61:  return s[61]  ^ s[23]  ^ s[0];
            default: return s[i];
        endcase
    endfunction

    function automatic logic m_maj(input logic a, input logic b, input logic c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    function automatic logic m_ch(input logic x, input logic y, input logic z);
        return x ? y : z;
    endfunction

    function automatic logic model_ks(input logic [292:0] s);
        return tap(s, 12) ^ tap(s, 154) ^ m_maj(tap(s, 235), tap(s, 61), tap(s, 193))
             ^ m_ch(tap(s, 230), tap(s, 111), tap(s, 66));
    endfunction

    function automatic logic [292:0] model_step(input logic [292:0] s, input logic ca, input logic m);
        logic [292:0] n;
        logic         fb;
        fb = tap(s, 0) ^ !tap(s, 107) ^ m_maj(tap(s, 244), tap(s, 23), tap(s, 160)) ^ (ca & tap(s, 196));
        for (int i = 0; i < 292; i++) n[i] = tap(s, i + 1);
        n[292] = fb ^ m;
        return n;
    endfunction

    function automatic logic [292:0] rand_state();
        logic [292:0] r;
        for (int i = 0; i < 293; i++) r[i] = 1'($urandom);
        return r;
    endfunction

    logic [63:0]  msg_p;
    logic [63:0]  msg_c;
    logic [292:0] exp_final;

    // Encrypt side: plaintext is fed back; then the post-message padding (if built).
    task automatic encrypt(input logic [292:0] st, input int len);
        logic [292:0] s;
        s = st;
        for (int i = 0; i < len; i++) begin
            msg_c[i] = msg_p[i] ^ model_ks(s);
            s = model_step(s, 1'b1, msg_p[i]);
        end
        for (int k = 0; k < PAD_LEN; k++) s = model_step(s, k < 128, k == 0);
        exp_final = s;
    endtask

    // mode 0: full rate, 1: p_ready held low for the first 5 cycles, 2: random valid/ready and stray loads.
    task automatic run_msg(input logic [292:0] st, input int len, input int mode, input string tag);
        int          sent, got, cyc, since, done_at, bp_acc;
        bit          late_ready, ready_seen, acc, drn, cv, pr;
        logic [63:0] rx;
        msg_p = {$urandom, $urandom};
        if (len < 64) msg_p = msg_p & ((64'd1 << len) - 64'd1);
        msg_c = '0;
        encrypt(st, len);
        sent = 0; got = 0; cyc = 0; since = -1; done_at = -1; bp_acc = 0;
        late_ready = 0; ready_seen = 0; rx = '0;
        @(negedge clk);
        load = 1'b1; load_empty = (len == 0); state_in = st;
        c_valid = 1'b0; c_last = 1'b0; p_ready = 1'b1;
        @(posedge clk);
        if (len == 0) since = 0;
        @(negedge clk);
        load = 1'b0; load_empty = 1'b0;
        check_i({tag, " ready_after_load"}, int'(c_ready), int'(len > 0));
        while ((sent < len || got < len || done_at < 0) && cyc < PAD_STEPS + 400) begin
            case (mode)
                1:       begin cv = 1'b1; pr = (cyc >= 5); end
                2:       begin cv = 1'($urandom); pr = 1'($urandom); end
                default: begin cv = 1'b1; pr = 1'b1; end
            endcase
            if (sent >= len) begin cv = 1'b0; pr = 1'b1; end
            c_valid  = cv;
            c_bit    = cv ? msg_c[sent] : 1'b0;
            c_last   = cv && (sent == len - 1);
            load     = (mode == 2) && (sent < len) && ($urandom_range(0, 7) == 0);
            state_in = rand_state();
            p_ready  = pr;
            #1;
            if (c_ready) ready_seen = 1'b1;
            if (mode == 1 && cyc >= 1 && cyc < 5 && c_ready) late_ready = 1'b1;
            acc = c_valid & c_ready;
            drn = p_valid & p_ready;
            if (mode == 1 && cyc < 5 && acc) bp_acc++;
            if (since >= 0 && done && done_at < 0) done_at = since;
            if (drn) begin
                if (got < 64) rx[got] = p_bit;
                got++;
            end
            if (acc) sent++;
            @(posedge clk);
            if (since >= 0) since++;
            else if (acc && c_last) since = 0;
            @(negedge clk);
            cyc++;
        end
        c_valid = 1'b0; c_last = 1'b0; load = 1'b0; p_ready = 1'b1;
        check_s({tag, " plaintext"}, 293'(rx), 293'(msg_p));
        check_i({tag, " bit_count"}, got, len);
        check_i({tag, " done_latency"}, done_at, PAD_LEN);
        check_s({tag, " final_state"}, state_out, exp_final);
        check_i({tag, " drained"}, int'(p_valid), 0);
        check_i({tag, " ready_seen"}, int'(ready_seen), int'(len > 0));
        if (mode == 1) begin
            check_i({tag, " bp_accepted"}, bp_acc, 1);
            check_i({tag, " bp_ready_low"}, int'(late_ready), 0);
        end
    endtask

    typedef struct {
        logic [292:0] st_in;
        logic         c_bit;
        logic         exp_p;
        logic [292:0] exp_s;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [292:0] ones;
        int           n;
        ones = '1;
        vecs[0] = '{st_in: '0,   c_bit: 1'b0, exp_p: 1'b0, exp_s: {1'b1, 292'd0}};
        vecs[1] = '{st_in: '0,   c_bit: 1'b1, exp_p: 1'b1, exp_s: '0};
        vecs[2] = '{st_in: ones, c_bit: 1'b0, exp_p: 1'b0, exp_s: ones};
        vecs[3] = '{st_in: ones, c_bit: 1'b1, exp_p: 1'b1, exp_s: {1'b0, ones[291:0]}};

        rst = 1'b1; load = 1'b0; load_empty = 1'b0; state_in = '0;
        c_valid = 1'b0; c_bit = 1'b0; c_last = 1'b0; p_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_i("reset c_ready", int'(c_ready), 0);
        check_i("reset p_valid", int'(p_valid), 0);
        check_i("reset p_bit", int'(p_bit), 0);
        check_i("reset done", int'(done), 0);
        check_s("reset state_out", state_out, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            load = 1'b1; state_in = vecs[i].st_in;
            @(negedge clk);
            load = 1'b0;
            c_valid = 1'b1; c_bit = vecs[i].c_bit; c_last = 1'b1;
            #1;
            check_i($sformatf("vec%0d c_ready", i), int'(c_ready), 1);
            @(posedge clk);
            @(negedge clk);
            c_valid = 1'b0; c_last = 1'b0;
            check_i($sformatf("vec%0d p_valid", i), int'(p_valid), 1);
            check_i($sformatf("vec%0d p_bit", i), int'(p_bit), int'(vecs[i].exp_p));
            check_s($sformatf("vec%0d state_out", i), state_out, vecs[i].exp_s);
            n = 0;
            while (!done && n < PAD_STEPS + 10) begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end
            check_i($sformatf("vec%0d done_latency", i), n, PAD_LEN);
        end

        run_msg(rand_state(), 64, 0, "roundtrip");
        run_msg(rand_state(), 16, 1, "backpressure");
        run_msg(rand_state(), 40, 2, "random_a");
        run_msg(rand_state(), 64, 2, "random_b");
        run_msg(rand_state(), 0, 0, "empty");

        // Reset mid-PAD at k=100 when padding is built, otherwise mid-RUN.
        @(negedge clk);
        load = 1'b1; state_in = rand_state();
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            c_valid = 1'b1; c_bit = 1'($urandom); c_last = (PAD_LEN > 0) && (i == 9);
            @(posedge clk);
            @(negedge clk);
        end
        c_valid = 1'b0; c_last = 1'b0;
        repeat (PAD_LEN > 0 ? 100 : 0) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_i("midrst c_ready", int'(c_ready), 0);
        check_i("midrst p_valid", int'(p_valid), 0);
        check_i("midrst p_bit", int'(p_bit), 0);
        check_i("midrst done", int'(done), 0);
        check_s("midrst state_out", state_out, '0);
        @(negedge clk);
        rst = 1'b0;
        run_msg(rand_state(), 32, 0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acorn128_dec_stream.md
# acorn128_dec_stream

Bit-serial ACORN-128 decryption engine: accepts ciphertext bits, produces plaintext bits, and advances the 293-bit cipher state one step per accepted bit, feeding the recovered plaintext bit (not the ciphertext) back into the state. It is the receive-side counterpart of the encrypt-side state update. It sits between the AD-absorption stage, which supplies the loaded state, and the finalization/tag stage, which consumes `state_out` once `done` is asserted. It includes the 256-step post-message padding.

## Interface
- `PAD_STEPS`, default 256: number of padding steps after the last ciphertext bit.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `load`  in  1  pulse; captures `state_in` and starts a message. Honoured in IDLE and DONE only.
- `load_empty`  in  1  sampled with `load`; 1 = zero-length message, skip RUN.
- `state_in`  in  293  state after AD absorption.
- `c_valid`  in  1  ciphertext bit valid.
- `c_bit`  in  1  ciphertext bit.
- `c_last`  in  1  marks final ciphertext bit; qualified by `c_valid & c_ready`.
- `c_ready`  out  1  engine can accept a ciphertext bit.
- `p_valid`  out  1  plaintext bit valid.
- `p_bit`  out  1  plaintext bit.
- `p_ready`  in  1  downstream accepts plaintext bit.
- `done`  out  1  padding complete; `state_out` is final.
- `state_out`  out  293  always equals the internal state register.

## Operation
- State register S[292:0]. One step, computed combinationally from S:
  - T = S with LFSR taps applied: T289=S289^S235^S230; T230=S230^S196^S193; T193=S193^S160^S154; T154=S154^S111^S107; T107=S107^S66^S61; T61=S61^S23^S0. All other bits unchanged.
  - ks = T12 ^ T154 ^ maj(T235,T61,T193) ^ ch(T230,T111,T66), where ch(x,y,z) = (x&y)^(~x&z).
  - f = T0 ^ ~T107 ^ maj(T244,T23,T160) ^ (ca&T196) ^ (cb&ks).
  - Next S = {f^m, T[292:1]}.
- FSM states:
  - IDLE: on `load`, S<=state_in. Go to PAD if `load_empty`, otherwise go to RUN.
  - RUN: ca=1, cb=0. On an accepted bit: m = c_bit^ks; step S; p_bit<=m; p_valid<=1. If `c_last`, go to PAD, with the pad counter cleared.
  - PAD: one step per cycle, unconditionally; counter k = 0..PAD_STEPS-1. m=1 when k=0, else 0. ca=1 when k<128, else 0. cb=0. After the step at k=PAD_STEPS-1, go to DONE.
  - DONE: `done`=1 and S frozen. `load` restarts the flow as in IDLE.
- Output register:
  - `p_valid` clears on `p_ready`.
  - c_ready = (FSM==RUN) & (!p_valid | p_ready), so at most one plaintext bit is pending.
- Pad counter width is ceil(log2(PAD_STEPS))+1 bits. It never wraps within a message.
- `load` in RUN or PAD is ignored.
- `c_valid` outside RUN is ignored; `c_ready` is 0 there.

## Timing
- Reset values: S=0, FSM=IDLE, `c_ready`=0, `p_valid`=0, `p_bit`=0, `done`=0, `state_out`=0, pad counter 0.
- `load` at edge N gives `c_ready`=1 in cycle N+1 (RUN).
- An accepted bit at edge N gives `p_valid`/`p_bit` and the updated `state_out` from cycle N+1.
- Sustained throughput is 1 bit/clk when `p_ready`=1.
- PAD lasts exactly PAD_STEPS cycles. `done` rises the cycle after the last pad step. With `p_ready`=1, the last ciphertext bit at edge N gives `done` from cycle N+PAD_STEPS+1.
- The pending plaintext bit from the `c_last` step can still be drained during PAD and DONE.
- `rst` mid-RUN or mid-PAD returns every output to its reset value immediately, with no partial-step commit.

## Configuration
- `ACORN_DEC_PAD_EN` defined:
  - padding as described above.
- `ACORN_DEC_PAD_EN` undefined:
  - the PAD state and counter are removed;
  - `c_last` and `load_empty` go straight to DONE;
  - `state_out` is the raw post-message state, and an external block pads.
  - `PAD_STEPS` is ignored.

## Test plan
- Zero-state single bit: load `state_in`=0, then send c_bit=0 with c_last=1.
  - Expect p_bit=0 (ks=0).
  - Expect `state_out`=0 except bit292=1 (f=1, m=0) in the cycle after acceptance.
  - Same test with c_bit=1: expect p_bit=1 and `state_out`=0.
- Round trip: encrypt a 64-bit random message from a random state with the encrypt-side model. Decrypt the ciphertext from the same state.
  - Expect the plaintext to match.
  - Expect the final `state_out` to equal the encrypt-side post-padding state.
- Backpressure: hold `p_ready`=0 for 5 cycles while `c_valid`=1.
  - Expect exactly one bit accepted and `c_ready`=0 until release.
  - No bit lost or duplicated.
- Empty message: `load` with `load_empty`=1.
  - Expect `done` exactly PAD_STEPS+1 cycles after the `load` edge.
  - Expect `c_ready` never asserted.
- Reset mid-PAD: assert `rst` at k=100.
  - Expect all outputs 0 and IDLE.
  - A new `load` then completes normally.
- Macro off: last bit accepted at edge N gives `done`=1 at cycle N+1, and `state_out` equals the unpadded model state.
